// File: rtl/div_rem_32_bit_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_rem_32_bit_if
//  Description : Request/response bundle for the iterative divider.
//                slave  modport -> divider side (requests in, results out)
//                master modport -> requester side
//  Signals     : i_start, i_op[1:0], i_dividend, i_divisor   (request)
//                o_busy, o_valid, o_quotient, o_remainder,
//                o_result                                    (response)
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_rem_32_bit_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             o_busy;
  logic             o_valid;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
  logic [WIDTH-1:0] o_result;

  modport slave (
    input  i_start, i_op, i_dividend, i_divisor,
    output o_busy, o_valid, o_quotient, o_remainder, o_result
  );

  modport master (
    output i_start, i_op, i_dividend, i_divisor,
    input  o_busy, o_valid, o_quotient, o_remainder, o_result
  );
endinterface
`default_nettype wire

// File: rtl/div_rem_32_bit.sv
`default_nettype none
// ============================================================================
//  Module      : div_rem_32_bit
//  Description : Multi-cycle restoring divider implementing the RV32M
//                DIV/DIVU/REM/REMU operations, one quotient bit per cycle.
//  Ports       : i_clk    - clock, rising edge
//                i_reset  - synchronous active-high reset
//                bus      - div_rem_32_bit_if.slave (request/response)
//  Revision    : 1.0 - initial release
// ============================================================================
module div_rem_32_bit #(
  parameter int WIDTH = 32
) (
  input  wire logic         i_clk,
  input  wire logic         i_reset,
  div_rem_32_bit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;
  logic [WIDTH-1:0] r_res_out;

  logic             w_accept;
  logic             w_signed;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic             w_last;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Request decode (only meaningful in IDLE)
  assign w_accept   = (r_state == S_IDLE) && bus.i_start;
  assign w_signed   = ~bus.i_op[0];
  assign w_div_zero = (bus.i_divisor == '0);
  assign w_ovf      = w_signed &&
                      (bus.i_dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (bus.i_divisor == '1);
  assign w_a_neg    = w_signed & bus.i_dividend[WIDTH-1];
  assign w_b_neg    = w_signed & bus.i_divisor[WIDTH-1];
  assign w_abs_a    = w_a_neg ? (-bus.i_dividend) : bus.i_dividend;
  assign w_abs_b    = w_b_neg ? (-bus.i_divisor)  : bus.i_divisor;

  // Partial remainder stays below the divisor, so the shifted value fits in
  // WIDTH+1 bits and the MSB of the difference is a clean sign bit.
  assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
  assign w_ge    = ~w_trial[WIDTH];
  assign w_last  = (r_cnt == CW'(WIDTH-1));

  // Sign correction: quotient negative when signs differ, remainder follows
  // the dividend.
  assign w_q_fix = r_neg_q ? (-r_quo) : r_quo;
  assign w_r_fix = r_neg_r ? (-r_rem) : r_rem;

  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_valid     = (r_state == S_DONE);
  assign bus.o_quotient  = r_q_out;
  assign bus.o_remainder = r_r_out;
  assign bus.o_result    = r_res_out;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_next = (w_div_zero || w_ovf) ? S_DONE : S_CALC;
        end
      end
      S_CALC:  if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath. Visible results are written only when an operation finishes,
  // so they hold steady while the next one is computing.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_is_rem  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_cnt     <= '0;
      r_q_out   <= '0;
      r_r_out   <= '0;
      r_res_out <= '0;
    end else if (w_accept) begin
      r_is_rem <= bus.i_op[1];
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_rem    <= '0;
      r_quo    <= w_abs_a;
      r_dvs    <= w_abs_b;
      r_cnt    <= '0;
      if (w_div_zero) begin
        r_q_out   <= '1;
        r_r_out   <= bus.i_dividend;
        r_res_out <= bus.i_op[1] ? bus.i_dividend : '1;
      end else if (w_ovf) begin
        // Overflow quotient equals the dividend (most negative value)
        r_q_out   <= bus.i_dividend;
        r_r_out   <= '0;
        r_res_out <= bus.i_op[1] ? '0 : bus.i_dividend;
      end
    end else if (r_state == S_CALC) begin
      r_quo <= {r_quo[WIDTH-2:0], w_ge};
      r_rem <= w_ge ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
      r_cnt <= r_cnt + CW'(1);
    end else if (r_state == S_FIX) begin
      r_q_out   <= w_q_fix;
      r_r_out   <= w_r_fix;
      r_res_out <= r_is_rem ? w_r_fix : w_q_fix;
    end
  end

endmodule
`default_nettype wire

// File: doc/div_rem_32_bit.md
DIV_REM_32_BIT -- requirements
Module: div_rem_32_bit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width; only 32 is required and verified.
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 i_clk  input  1  clock; all state updates occur on the rising edge.
REQ-004 i_reset  input  1  synchronous active-high reset.
REQ-005 i_start  input  1  request; sampled only when o_busy=0.
REQ-006 i_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (equal to RV32M funct3[1:0]).
REQ-007 i_dividend  input  WIDTH  dividend; captured when a start is accepted.
REQ-008 i_divisor  input  WIDTH  divisor; captured when a start is accepted.
REQ-009 o_busy  output  1  high while a request is in flight (any state other than IDLE).
REQ-010 o_valid  output  1  one-cycle pulse: results are final.
REQ-011 o_quotient  output  WIDTH  final quotient.
REQ-012 o_remainder  output  WIDTH  final remainder.
REQ-013 o_result  output  WIDTH  o_quotient for DIV/DIVU, o_remainder for REM/REMU.

Function
REQ-014 SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-015 SHALL accept a start only when i_start=1 in IDLE; on the accepting edge it registers the operands and i_op and clears the iteration counter.
REQ-016 Signed ops (DIV, REM) SHALL divide the absolute values of the operands and record the sign of each operand.
REQ-017 IDLE->CALC on an accepted start; IDLE->DONE directly if the divisor is 0 or the op is signed with dividend 0x80000000 and divisor 0xFFFFFFFF.
REQ-018 CALC SHALL perform one restoring step per cycle: shift {remainder, quotient} left by 1, trial-subtract the divisor (WIDTH+1-bit subtraction), keep the difference and set the quotient LSB to 1 if the result is non-negative, otherwise restore and set the LSB to 0.
REQ-019 CALC->FIX after exactly WIDTH steps, when the counter reaches WIDTH-1.
REQ-020 FIX SHALL negate the quotient when the op is signed and the operand signs differ, SHALL give the remainder the sign of the dividend for signed ops, and then go to DONE.
REQ-021 DONE SHALL assert o_valid for exactly one cycle and then go to IDLE.
REQ-022 Normal latency: start high in cycle 0 -> o_valid high in cycle WIDTH+2 (cycle 34 for WIDTH=32); special cases -> o_valid high in cycle 1.
REQ-023 Divide by zero SHALL give o_quotient=all ones and o_remainder=dividend, for both signed and unsigned ops.
REQ-024 Signed overflow (0x80000000 / -1) SHALL give o_quotient=0x80000000 and o_remainder=0.
REQ-025 o_quotient, o_remainder and o_result SHALL hold their last value from o_valid until the next accepted start completes; they SHALL NOT change during CALC/FIX.
REQ-026 i_start while o_busy=1, including in DONE, SHALL be ignored; it is neither queued nor allowed to corrupt the in-flight operands.
REQ-027 Operand or i_op changes after the accepting edge SHALL NOT affect the in-flight result.
REQ-028 Back-to-back: a start in the cycle after o_valid, when o_busy=0, SHALL be accepted.

Reset
REQ-029 i_reset=1 SHALL force state IDLE, o_busy=0, o_valid=0, o_quotient=0, o_remainder=0, o_result=0 and counter=0 on the next edge.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no o_valid pulse; reset has priority over i_start.
REQ-031 After reset deasserts, a start in the first cycle SHALL be accepted.

Verification
REQ-032 DIVU 100/7, start cycle 0 -> o_valid cycle 34, quotient=14, remainder=2, o_busy 1 for cycles 1..34.
REQ-033 DIV -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; REM 7/-2 -> o_result=1, o_quotient=0xFFFFFFFD.
REQ-034 DIVU 5/0 and DIV 0x80000000/0xFFFFFFFF -> o_valid in cycle 1 with (0xFFFFFFFF, 5) and (0x80000000, 0) respectively.
REQ-035 Start DIVU 100/7, pulse i_start with 9/3 at cycle 10 -> only one o_valid, at cycle 34, with results 14/2; issue 9/3 at cycle 35 -> o_valid cycle 69, quotient 3, remainder 0.
REQ-036 Reset at cycle 10 of an operation -> no o_valid, all outputs 0 next cycle; a new DIVU 0xFFFFFFFF/1 then completes with quotient 0xFFFFFFFF, remainder 0.
REQ-037 Random signed and unsigned operand sweep, at least 10k ops including 0, 1, -1, 0x80000000 and 0x7FFFFFFF, -> matches an RV32M reference model.
